// File: rtl/spi_slave_mem_pkg.sv
// Shared definitions for the SPI mode-0 serial-EEPROM emulator: opcodes,
// FSM state type, page geometry and the status-register layout.
package spi_slave_mem_pkg;

  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_WREN  = 8'h06;
  localparam logic [7:0] OP_WRDI  = 8'h04;
  localparam logic [7:0] OP_RDSR  = 8'h05;

  localparam int PAGE_BYTES = 16;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA_RD,
    DATA_WR,
    STAT,
    IGNORE
  } state_t;

  // Status register as seen by RDSR: only the write-enable latch is live.
  function automatic logic [7:0] status_byte(input logic wel);
    return {6'b0, wel, 1'b0};
  endfunction

endpackage

// File: rtl/spi_slave_sync.sv
// Multi-stage synchronizer for one asynchronous SPI pin, followed by
// rise/fall detection on the synchronized level. Pulses are one CLK cycle.
module spi_slave_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  // Next values: shift the pin into the chain, remember the last level.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d_i};
    prev_d = sync_q[STAGES-1];
  end

  // Synchronizer chain and edge-detect history register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = sync_q[STAGES-1] & ~prev_q;
  assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave_mem.sv
// SPI mode-0 slave emulating a 25AA-style EEPROM (READ/WRITE/WREN/WRDI/RDSR)
// over an internal byte array. All SPI pins are oversampled in CLK_I.
// Optional build macro SPI_SLAVE_MEM_PAGE_WRAP_EN: write bursts wrap inside
// a 16-byte page instead of across the whole array.
module spi_slave_mem
  import spi_slave_mem_pkg::*;
#(
  parameter int ADDR_W      = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  input  logic              SCK,
  input  logic              CS_N,
  input  logic              MOSI,
  output logic              MISO,
  output logic              MISO_OE,
  output logic              BUSY,
  output logic              WR_STB,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic [7:0]        WR_DATA
);

`ifdef SPI_SLAVE_MEM_PAGE_WRAP_EN
  localparam logic [ADDR_W-1:0] PAGE_MASK = ADDR_W'(PAGE_BYTES - 1);
`endif

  logic sck_rise, sck_fall, sck_level_unused;
  logic cs_rise, cs_fall, cs_level;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  spi_slave_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clk_i(CLK_I), .rst_i(RST_I), .d_i(SCK),
    .level_o(sck_level_unused), .rise_o(sck_rise), .fall_o(sck_fall)
  );

  // CS_N resets to its idle (high) level so reset release creates no edge.
  spi_slave_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk_i(CLK_I), .rst_i(RST_I), .d_i(CS_N),
    .level_o(cs_level), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  spi_slave_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk_i(CLK_I), .rst_i(RST_I), .d_i(MOSI),
    .level_o(mosi_s), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
  );

  logic [7:0] mem [2**ADDR_W];

  state_t            state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic [7:0]        tx_q, tx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              cmd_rd_q, cmd_rd_d;       // opcode was READ (else WRITE)
  logic              wel_q, wel_d;
  logic              wren_pend_q, wren_pend_d; // WREN seen; WEL sets at CS_N rise
  logic              committed_q, committed_d; // a byte was written this burst
  logic              load_pend_q, load_pend_d; // next SCK fall loads a new byte
  logic              miso_q, miso_d;
  logic              miso_oe_q, miso_oe_d;
  logic              wr_stb_q, wr_stb_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;

  logic [7:0]        rx_byte, load_byte;
  logic [ADDR_W-1:0] addr_inc, addr_wr_next;
  logic              mem_we;

  // Next-state and output logic: CS_N edges take priority over SCK edges.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    tx_d        = tx_q;
    addr_d      = addr_q;
    cmd_rd_d    = cmd_rd_q;
    wel_d       = wel_q;
    wren_pend_d = wren_pend_q;
    committed_d = committed_q;
    load_pend_d = load_pend_q;
    miso_d      = miso_q;
    miso_oe_d   = miso_oe_q;
    wr_stb_d    = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    mem_we      = 1'b0;
    load_byte   = 8'h00;
    rx_byte     = {shift_q[6:0], mosi_s};
    addr_inc    = addr_q + 1'b1;
`ifdef SPI_SLAVE_MEM_PAGE_WRAP_EN
    addr_wr_next = (addr_q & ~PAGE_MASK) | (addr_inc & PAGE_MASK);
`else
    addr_wr_next = addr_inc;
`endif

    if (cs_rise) begin
      state_d     = IDLE;
      bit_cnt_d   = 3'd0;
      miso_d      = 1'b0;
      miso_oe_d   = 1'b0;
      load_pend_d = 1'b0;
      if (wren_pend_q) wel_d = 1'b1;
      if (state_q == DATA_WR && committed_q) wel_d = 1'b0;
      wren_pend_d = 1'b0;
      committed_d = 1'b0;
    end else if (cs_fall) begin
      state_d     = CMD;
      bit_cnt_d   = 3'd0;
      miso_oe_d   = 1'b0;
      load_pend_d = 1'b0;
      wren_pend_d = 1'b0;
      committed_d = 1'b0;
    end else if (!cs_level && state_q != IDLE) begin
      if (sck_rise) begin
        shift_d   = rx_byte;
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          case (state_q)
            CMD: begin
              case (rx_byte)
                OP_READ, OP_WRITE: begin
                  cmd_rd_d = (rx_byte == OP_READ);
                  state_d  = ADDR;
                end
                OP_WREN: begin
                  wren_pend_d = 1'b1;
                  state_d     = IGNORE;
                end
                OP_WRDI: begin
                  wel_d   = 1'b0;
                  state_d = IGNORE;
                end
                OP_RDSR: begin
                  load_pend_d = 1'b1;
                  state_d     = STAT;
                end
                default: state_d = IGNORE;
              endcase
            end
            ADDR: begin
              addr_d = rx_byte[ADDR_W-1:0];
              if (cmd_rd_q) begin
                load_pend_d = 1'b1;
                state_d     = DATA_RD;
              end else if (wel_q) begin
                state_d = DATA_WR;
              end else begin
                state_d = IGNORE;
              end
            end
            DATA_RD: begin
              addr_d      = addr_inc;
              load_pend_d = 1'b1;
            end
            DATA_WR: begin
              mem_we      = 1'b1;
              wr_stb_d    = 1'b1;
              wr_addr_d   = addr_q;
              wr_data_d   = rx_byte;
              committed_d = 1'b1;
              addr_d      = addr_wr_next;
            end
            STAT:    load_pend_d = 1'b1;
            default: ;
          endcase
        end
      end else if (sck_fall) begin
        if (load_pend_q) begin
          load_byte   = (state_q == STAT) ? status_byte(wel_q) : mem[addr_q];
          miso_d      = load_byte[7];
          tx_d        = {load_byte[6:0], 1'b0};
          miso_oe_d   = 1'b1;
          load_pend_d = 1'b0;
        end else if (miso_oe_q) begin
          miso_d = tx_q[7];
          tx_d   = {tx_q[6:0], 1'b0};
        end
      end
    end
  end

  // State and output registers.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      tx_q        <= 8'h00;
      addr_q      <= '0;
      cmd_rd_q    <= 1'b0;
      wel_q       <= 1'b0;
      wren_pend_q <= 1'b0;
      committed_q <= 1'b0;
      load_pend_q <= 1'b0;
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
      wr_stb_q    <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      addr_q      <= addr_d;
      cmd_rd_q    <= cmd_rd_d;
      wel_q       <= wel_d;
      wren_pend_q <= wren_pend_d;
      committed_q <= committed_d;
      load_pend_q <= load_pend_d;
      miso_q      <= miso_d;
      miso_oe_q   <= miso_oe_d;
      wr_stb_q    <= wr_stb_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  // Byte array write port.
  // NOTE: the array has no reset so it can map onto RAM; contents survive RST_I.
  always_ff @(posedge CLK_I) begin
    if (mem_we) mem[addr_q] <= rx_byte;
  end

  assign MISO    = miso_q;
  assign MISO_OE = miso_oe_q;
  assign BUSY    = ~cs_level;
  assign WR_STB  = wr_stb_q;
  assign WR_ADDR = wr_addr_q;
  assign WR_DATA = wr_data_q;

endmodule

// File: tb/tb_spi_slave_mem.sv
// Self-checking bench for spi_slave_mem: a bit-banged SPI master drives
// transactions; a transaction-level EEPROM model predicts read data, MISO_OE
// windows, committed writes and the WEL latch.
module tb_spi_slave_mem;

  localparam int ADDR_W = 7;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int H      = 8;   // SCK half period in CLK_I cycles
  localparam int MAXB   = 20;

  logic              CLK_I = 1'b0;
  logic              RST_I = 1'b1;
  logic              SCK   = 1'b0;
  logic              CS_N  = 1'b1;
  logic              MOSI  = 1'b0;
  logic              MISO, MISO_OE, BUSY, WR_STB;
  logic [ADDR_W-1:0] WR_ADDR;
  logic [7:0]        WR_DATA;

  always #5 CLK_I = ~CLK_I;

  spi_slave_mem #(.ADDR_W(ADDR_W), .SYNC_STAGES(2)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .SCK(SCK), .CS_N(CS_N), .MOSI(MOSI),
    .MISO(MISO), .MISO_OE(MISO_OE), .BUSY(BUSY), .WR_STB(WR_STB),
    .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state.
  logic [7:0]        mem_m [DEPTH];
  logic              wel_m;
  logic [ADDR_W+7:0] act_wr[$];
  logic [ADDR_W+7:0] exp_wr[$];

  // Transaction description and results.
  logic [7:0] tx_buf [MAXB];
  int         tx_len;
  int         part_bits = 0;
  logic [7:0] part_val  = 8'h00;
  bit         sim_abort = 0;
  bit         rst_mid   = 0;
  logic [7:0] rx_buf [MAXB];
  logic       oe_all [MAXB];
  logic       oe_any [MAXB];
  logic [7:0] exp_rx [MAXB];
  bit         exp_oe [MAXB];
  logic       busy_seen, busy_after;

  // Write-strobe monitor.
  always @(negedge CLK_I) begin
    if (WR_STB === 1'b1) act_wr.push_back({WR_ADDR, WR_DATA});
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic half();
    repeat (H) @(negedge CLK_I);
  endtask

  task automatic shift_bit(input logic b, input bit abort, output logic m, output logic o);
    MOSI = b;
    half();
    SCK = 1'b1;
    if (abort) CS_N = 1'b1;
    m = MISO;
    o = MISO_OE;
    half();
    SCK = 1'b0;
  endtask

  // Drive one CS_N-framed transaction from tx_buf, plus optional tail bits.
  task automatic run_txn();
    logic m, o;
    logic [7:0] r;
    CS_N = 1'b0;
    half();
    for (int i = 0; i < tx_len; i++) begin
      r = 8'h00;
      oe_all[i] = 1'b1;
      oe_any[i] = 1'b0;
      for (int b = 7; b >= 0; b--) begin
        shift_bit(tx_buf[i][b], 1'b0, m, o);
        r = {r[6:0], m};
        oe_all[i] = oe_all[i] & o;
        oe_any[i] = oe_any[i] | o;
      end
      rx_buf[i] = r;
    end
    busy_seen = BUSY;
    for (int b = 0; b < part_bits; b++)
      shift_bit(part_val[7-b], sim_abort && (b == part_bits - 1), m, o);
    if (rst_mid) begin
      RST_I = 1'b1;
      #1;
      check("rst_mid MISO_OE", MISO_OE, 0);
      check("rst_mid WR_STB", WR_STB, 0);
      check("rst_mid BUSY", BUSY, 0);
      repeat (2) @(negedge CLK_I);
      RST_I = 1'b0;
    end
    half();
    CS_N = 1'b1;
    repeat (2 * H) @(negedge CLK_I);
    busy_after = BUSY;
  endtask

  function automatic logic [ADDR_W-1:0] wr_next(input logic [ADDR_W-1:0] a);
`ifdef SPI_SLAVE_MEM_PAGE_WRAP_EN
    return {a[ADDR_W-1:4], a[3:0] + 4'd1};
`else
    return a + 1'b1;
`endif
  endfunction

  // Transaction-level EEPROM behaviour; the tail (partial byte) is discarded.
  task automatic model_txn();
    logic [ADDR_W-1:0] a;
    bit wrote;
    wrote = 0;
    for (int i = 0; i < MAXB; i++) begin
      exp_oe[i] = 0;
      exp_rx[i] = 8'h00;
    end
    a = tx_buf[1][ADDR_W-1:0];
    case (tx_buf[0])
      8'h03: for (int i = 2; i < tx_len; i++) begin
        exp_rx[i] = mem_m[a];
        exp_oe[i] = 1;
        a = a + 1'b1;
      end
      8'h02: if (wel_m) for (int i = 2; i < tx_len; i++) begin
        mem_m[a] = tx_buf[i];
        exp_wr.push_back({a, tx_buf[i]});
        wrote = 1;
        a = wr_next(a);
      end
      8'h05: for (int i = 1; i < tx_len; i++) begin
        exp_rx[i] = {6'b0, wel_m, 1'b0};
        exp_oe[i] = 1;
      end
      8'h06: wel_m = 1'b1;
      8'h04: wel_m = 1'b0;
      default: ;
    endcase
    if (wrote) wel_m = 1'b0;
    if (rst_mid) wel_m = 1'b0;
  endtask

  task automatic compare_txn(input string tag);
    int n;
    for (int i = 0; i < tx_len; i++) begin
      if (exp_oe[i]) begin
        check($sformatf("%s rx[%0d]", tag, i), rx_buf[i], exp_rx[i]);
        check($sformatf("%s oe_hi[%0d]", tag, i), oe_all[i], 1);
      end else begin
        check($sformatf("%s oe_lo[%0d]", tag, i), oe_any[i], 0);
      end
    end
    check($sformatf("%s busy", tag), busy_seen, 1);
    check($sformatf("%s busy_idle", tag), busy_after, 0);
    check($sformatf("%s wr_count", tag), act_wr.size(), exp_wr.size());
    n = (act_wr.size() < exp_wr.size()) ? act_wr.size() : exp_wr.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s wr[%0d]", tag, i), act_wr[i], exp_wr[i]);
    act_wr.delete();
    exp_wr.delete();
  endtask

  task automatic do_txn(input string tag);
    model_txn();
    run_txn();
    compare_txn(tag);
    part_bits = 0;
    sim_abort = 0;
    rst_mid   = 0;
  endtask

  task automatic set_cmd(input logic [7:0] op, input logic [7:0] adr, input int len);
    for (int i = 0; i < MAXB; i++) tx_buf[i] = 8'($urandom);
    tx_buf[0] = op;
    tx_buf[1] = adr;
    tx_len    = len;
  endtask

  initial begin
    logic [ADDR_W+7:0] e;
    wel_m = 1'b0;

    // Reset state
    repeat (3) @(negedge CLK_I);
    check("reset MISO", MISO, 0);
    check("reset MISO_OE", MISO_OE, 0);
    check("reset BUSY", BUSY, 0);
    check("reset WR_STB", WR_STB, 0);
    check("reset WR_ADDR", WR_ADDR, 0);
    check("reset WR_DATA", WR_DATA, 0);
    RST_I = 1'b0;
    repeat (4) @(negedge CLK_I);
    check("post-reset BUSY", BUSY, 0);

    // Fill the whole array page by page with random data
    for (int p = 0; p < DEPTH / 16; p++) begin
      set_cmd(8'h06, 8'h00, 1);
      do_txn("preload wren");
      set_cmd(8'h02, 8'(p * 16), 18);
      do_txn($sformatf("preload page %0d", p));
    end

    // WREN, WRITE 0x10 A5 3C, then RDSR shows WEL cleared
    set_cmd(8'h06, 8'h00, 1);
    do_txn("t1 wren");
    set_cmd(8'h02, 8'h10, 4);
    tx_buf[2] = 8'hA5;
    tx_buf[3] = 8'h3C;
    do_txn("t1 write");
    set_cmd(8'h05, 8'h00, 3);
    do_txn("t1 rdsr");

    // WRITE without WREN is dropped; READ 0x10 returns old contents
    set_cmd(8'h02, 8'h10, 4);
    do_txn("t2 write");
    set_cmd(8'h03, 8'h10, 4);
    do_txn("t2 read");

    // READ across the top of the array
    set_cmd(8'h03, 8'h7F, 4);
    do_txn("t3 read wrap");

    // WREN then RDSR repeats 0x02
    set_cmd(8'h06, 8'h00, 1);
    do_txn("t4 wren");
    set_cmd(8'h05, 8'h00, 3);
    do_txn("t4 rdsr");

    // Partial data byte is discarded, WEL survives
    set_cmd(8'h02, 8'h20, 2);
    part_bits = 4;
    part_val  = 8'h5A;
    do_txn("t5 partial");
    set_cmd(8'h03, 8'h20, 3);
    do_txn("t5 read");
    set_cmd(8'h05, 8'h00, 2);
    do_txn("t5 rdsr");

    // Write burst crossing a page boundary
    set_cmd(8'h06, 8'h00, 1);
    do_txn("t6 wren");
    set_cmd(8'h02, 8'h1F, 4);
    tx_buf[2] = 8'h11;
    tx_buf[3] = 8'h22;
    model_txn();
    run_txn();
    if (act_wr.size() >= 2) begin
      e = act_wr[0];
      check("t6 first WR_ADDR", e[ADDR_W+7:8], 7'h1F);
      e = act_wr[1];
`ifdef SPI_SLAVE_MEM_PAGE_WRAP_EN
      check("t6 second WR_ADDR", e[ADDR_W+7:8], 7'h10);
`else
      check("t6 second WR_ADDR", e[ADDR_W+7:8], 7'h20);
`endif
    end
    compare_txn("t6 write");

    // CS_N rise coincident with the 8th SCK rise aborts that byte
    set_cmd(8'h06, 8'h00, 1);
    do_txn("t7 wren");
    set_cmd(8'h02, 8'h40, 3);
    tx_buf[2] = 8'h77;
    part_bits = 8;
    part_val  = 8'h88;
    sim_abort = 1;
    do_txn("t7 abort");
    set_cmd(8'h05, 8'h00, 2);
    do_txn("t7 rdsr");
    set_cmd(8'h03, 8'h40, 4);
    do_txn("t7 read");

    // Reset mid-transaction keeps committed bytes and clears WEL
    set_cmd(8'h06, 8'h00, 1);
    do_txn("t8 wren");
    set_cmd(8'h02, 8'h30, 3);
    part_bits = 3;
    part_val  = 8'hE0;
    rst_mid   = 1;
    do_txn("t8 write rst");
    set_cmd(8'h03, 8'h30, 3);
    do_txn("t8 read");
    set_cmd(8'h05, 8'h00, 2);
    do_txn("t8 rdsr");

    // Random transaction mix
    for (int t = 0; t < 24; t++) begin
      int kind, n;
      kind = int'($urandom_range(0, 5));
      n    = int'($urandom_range(1, 4));
      case (kind)
        0: set_cmd(8'h03, 8'($urandom_range(0, DEPTH - 1)), 2 + n);
        1: set_cmd(8'h02, 8'($urandom_range(0, DEPTH - 1)), 2 + n);
        2: set_cmd(8'h06, 8'h00, 1);
        3: set_cmd(8'h04, 8'h00, 1);
        4: set_cmd(8'h05, 8'h00, 1 + n);
        default: set_cmd(8'h80 | 8'($urandom), 8'h00, 1 + n);
      endcase
      if ($urandom_range(0, 3) == 0) begin
        part_bits = int'($urandom_range(1, 7));
        part_val  = 8'($urandom);
      end
      do_txn($sformatf("rand %0d kind %0d", t, kind));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spi_slave_mem.md
Name: spi_slave_mem

Overview:
- Synthesizable SPI mode-0 slave that emulates a 25AA-style serial EEPROM command set over an internal byte array.
- Forms the far end of the SPI link driven by the team's SPI master. Replaces the behavioural memory model in synthesizable builds and serves as a loopback target on FPGA.
- SCK, CS_N and MOSI are oversampled in the CLK_I domain; there is no second clock.

Parameters:
- ADDR_W, 7, byte-address width; array depth is 2**ADDR_W bytes.
- SYNC_STAGES, 2, flip-flop stages on each of SCK, CS_N and MOSI (minimum 2).

Ports:
- CLK_I  in  1  system clock. Must run at ≥ 8× SCK frequency.
- RST_I  in  1  asynchronous, active-high reset.
- SCK  in  1  SPI serial clock from the master; idles low (mode 0).
- CS_N  in  1  chip select, active low.
- MOSI  in  1  serial data from the master, MSB first.
- MISO  out  1  serial data to the master, MSB first.
- MISO_OE  out  1  high while MISO carries valid read or status data.
- BUSY  out  1  high while CS_N is low (synchronized).
- WR_STB  out  1  one-cycle pulse on each committed byte write.
- WR_ADDR  out  ADDR_W  address of the committed write; valid with WR_STB.
- WR_DATA  out  8  data of the committed write; valid with WR_STB.

Behaviour:
- Reset values: MISO=0, MISO_OE=0, BUSY=0, WR_STB=0, WR_ADDR=0, WR_DATA=0. Reset also sets state=IDLE, bit counter=0, WEL=0. Array contents are not reset.
- Input conditioning: SYNC_STAGES flops per input, then rise/fall detect on synced SCK and CS_N. Latency from a pin edge to the internal event is SYNC_STAGES+1 CLK_I cycles.
- Sampling and driving: MOSI is sampled on SCK rise. MISO updates on SCK fall and is registered.
- Bit counter: 3 bits, cleared on CS_N fall. On each 8th rise the assembled byte is handed to the FSM.
- Opcodes: READ 0x03, WRITE 0x02, WREN 0x06, WRDI 0x04, RDSR 0x05.
- State transitions:
  - IDLE -> CMD on CS_N fall.
  - CMD: on the opcode byte:
    - READ/WRITE -> ADDR.
    - WREN: WEL=1 at CS_N rise, then -> IGNORE.
    - WRDI: WEL=0, then -> IGNORE.
    - RDSR -> STAT.
    - Any other value -> IGNORE.
  - ADDR: latch the address byte (low ADDR_W bits used).
    - After READ -> DATA_RD.
    - After WRITE with WEL=1 -> DATA_WR.
    - After WRITE with WEL=0 -> IGNORE.
  - DATA_RD: on the SCK fall following the final address-bit rise, load mem[addr], set MISO to its bit 7 and MISO_OE=1. Each completed byte increments addr (wraps 2**ADDR_W-1 -> 0) and preloads the next byte.
  - DATA_WR: each complete received byte writes mem[addr], pulses WR_STB with WR_ADDR/WR_DATA, then increments addr.
  - STAT: shift out {6'b0, WEL, 1'b0} repeatedly.
  - IGNORE: hold MISO_OE=0 until CS_N rises.
- Any state goes to IDLE on CS_N rise. MISO_OE=0 and the bit counter is cleared. A partial byte is discarded and never written.
- WEL is cleared at the CS_N rise that ends a WRITE transaction in which at least one byte was committed.
- Simultaneous events: a CS_N rise and an SCK edge detected in the same cycle resolve to CS_N (abort); the SCK edge is ignored.
- RST_I asserted mid-transaction: immediate return to IDLE. A byte in progress is lost and already-committed bytes persist.
- When CS_N is high, SCK activity is ignored.

Optional Feature:
- Macro: SPI_SLAVE_MEM_PAGE_WRAP_EN.
- Defined: during DATA_WR, address increment wraps within a 16-byte page, so addr[3:0] wraps and the upper bits hold. READ still wraps across the full array.
- Undefined: WRITE increments across the full array, same as READ.

Decomposition:
- Package spi_slave_mem_pkg: opcode localparams, state enum type (IDLE, CMD, ADDR, DATA_RD, DATA_WR, STAT, IGNORE), PAGE_BYTES=16.
- Sub-module spi_slave_sync: SYNC_STAGES synchronizer plus rise/fall pulse outputs, instantiated for SCK, CS_N and MOSI (MOSI uses the level only).

Test Plan:
- WREN, then WRITE addr 0x10 with data 0xA5,0x3C -> WR_STB pulses at (0x10,0xA5) then (0x11,0x3C). RDSR afterwards returns 0x00 because WEL was cleared.
- WRITE without a prior WREN -> no WR_STB; a following READ at 0x10 returns the previous contents.
- READ addr 0x7F (ADDR_W=7) for two bytes -> returns mem[0x7F] then mem[0x00]; MISO_OE is high only during the data bytes.
- WREN, then RDSR -> MISO shifts 0x02, and repeats 0x02 across a second byte.
- WREN, WRITE addr 0x20, then 4 data bits and CS_N rise -> no WR_STB, mem[0x20] unchanged, and the next CS_N fall starts a clean CMD.
- With SPI_SLAVE_MEM_PAGE_WRAP_EN defined: WREN, WRITE addr 0x1F with 0x11,0x22 -> WR_ADDR 0x1F then 0x10. With the macro undefined -> 0x1F then 0x20.
